// File: rtl/jk_down_counter.sv
// -----------------------------------------------------------------------------
// jk_down_counter
//
// Synchronous down counter made of WIDTH JK flip-flop stages, all clocked by
// one clock. The global J/K inputs select the mode for the whole register:
//   J K = 0 0 hold, 0 1 clear, 1 0 set (to TOP), 1 1 count down.
// Parallel load takes priority over the J/K mode. Synchronous reset takes
// priority over everything. Every command is applied through the per-stage
// J/K inputs, so there is no adder in the data path. When counting, bit i
// toggles if all lower bits are 0. Bit 0 always toggles.
//
// Optional feature, controlled by the macro JK_MOD_RELOAD_EN:
//   defined   : TOP = MOD-1. Wrap, set and load saturate at MOD-1.
//               A count edge at Q >= MOD forces MOD-1, so the counter
//               recovers from any out-of-range value.
//   undefined : MOD is ignored. TOP = 2^WIDTH-1. din is loaded unmodified.
//
// Ports
//   clock  in   1      clock; all state changes on its rising edge
//   reset  in   1      synchronous, active-high reset
//   J, K   in   1      mode select with JK semantics
//   load   in   1      parallel load strobe
//   din    in   WIDTH  parallel load value
//   Q      out  WIDTH  registered count
//   borrow out  1      registered pulse, high for the one cycle after a wrap
//   zero   out  1      combinational, high when Q == 0
// -----------------------------------------------------------------------------
module jk_down_counter #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             J,
    input  logic             K,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] Q,
    output logic             borrow,
    output logic             zero
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_CLEAR = 2'b01,
        MODE_SET   = 2'b10,
        MODE_COUNT = 2'b11
    } mode_e;

    // Elaboration-time range checks on the parameters.
    if (WIDTH < 2 || WIDTH > 8) begin : g_bad_width
        $error("jk_down_counter: WIDTH must be in 2..8");
    end
    if (MOD < 2 || MOD > (2 ** WIDTH)) begin : g_bad_mod
        $error("jk_down_counter: MOD must be in 2..2^WIDTH");
    end

`ifdef JK_MOD_RELOAD_EN
    localparam logic [WIDTH-1:0] TOP     = WIDTH'(MOD - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);
`else
    localparam logic [WIDTH-1:0] TOP     = {WIDTH{1'b1}};
`endif

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             borrow_q;
    logic             borrow_d;

    mode_e            mode_s;
    logic [WIDTH-1:0] din_eff_s;
    logic             reload_s;
    logic [WIDTH-1:0] toggle_s;
    logic [WIDTH-1:0] forced_s;
    logic             force_en_s;
    logic [WIDTH-1:0] stage_j_s;
    logic [WIDTH-1:0] stage_k_s;

    assign mode_s = mode_e'({J, K});

    // Load value and reload condition, saturated to MOD-1 when the modulus feature is on.
    always_comb begin
`ifdef JK_MOD_RELOAD_EN
        if ({1'b0, din} >= MOD_EXT) begin
            din_eff_s = TOP;
        end else begin
            din_eff_s = din;
        end
        // Both a genuine wrap (Q==0) and an out-of-range Q must land on MOD-1,
        // which the plain toggle chain would not produce.
        if ((count_q == '0) || ({1'b0, count_q} >= MOD_EXT)) begin
            reload_s = 1'b1;
        end else begin
            reload_s = 1'b0;
        end
`else
        din_eff_s = din;
        // At Q==0 the toggle chain flips every bit, which gives 2^WIDTH-1 directly.
        reload_s  = 1'b0;
`endif
    end

    // Toggle enables of the count chain: stage i toggles when all lower bits are 0.
    always_comb begin
        toggle_s    = '0;
        toggle_s[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            toggle_s[i] = toggle_s[i-1] & ~count_q[i-1];
        end
    end

    // Mode decode into per-stage J/K drives and the borrow request.
    always_comb begin
        force_en_s = 1'b0;
        forced_s   = '0;
        borrow_d   = 1'b0;
        stage_j_s  = '0;
        stage_k_s  = '0;
        if (load) begin
            force_en_s = 1'b1;
            forced_s   = din_eff_s;
        end else begin
            case (mode_s)
                MODE_HOLD: begin
                    force_en_s = 1'b0;
                end
                MODE_CLEAR: begin
                    force_en_s = 1'b1;
                    forced_s   = '0;
                end
                MODE_SET: begin
                    force_en_s = 1'b1;
                    forced_s   = TOP;
                end
                MODE_COUNT: begin
                    // Only a wrap from 0 is a borrow; recovery from Q >= MOD is not.
                    borrow_d = (count_q == '0);
                    if (reload_s) begin
                        force_en_s = 1'b1;
                        forced_s   = TOP;
                    end else begin
                        stage_j_s = toggle_s;
                        stage_k_s = toggle_s;
                    end
                end
                default: begin
                    force_en_s = 1'b0;
                end
            endcase
        end
        // Forcing a stage to value v is J=v, K=~v.
        if (force_en_s) begin
            stage_j_s = forced_s;
            stage_k_s = ~forced_s;
        end else begin
            stage_j_s = stage_j_s;
            stage_k_s = stage_k_s;
        end
    end

    // JK characteristic equation applied per stage: Q+ = J&~Q | ~K&Q.
    always_comb begin
        count_d = (stage_j_s & ~count_q) | (~stage_k_s & count_q);
    end

    // Counter stages and borrow flag, with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q  <= '0;
            borrow_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            borrow_q <= borrow_d;
        end
    end

    assign Q      = count_q;
    assign borrow = borrow_q;
    assign zero   = (count_q == '0);

endmodule

// File: tb/tb_jk_down_counter.sv
module tb_jk_down_counter;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;
`ifdef JK_MOD_RELOAD_EN
    localparam int TOP   = MOD - 1;
    localparam int SAT   = 1;
`else
    localparam int TOP   = (1 << WIDTH) - 1;
    localparam int SAT   = 0;
`endif

    logic             clock;
    logic             reset;
    logic             J;
    logic             K;
    logic             load;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] Q;
    logic             borrow;
    logic             zero;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state (integer count and borrow flag)
    int m_q         = 0;
    int m_b         = 0;
    bit model_valid = 1'b0;

    jk_down_counter #(.WIDTH(WIDTH), .MOD(MOD)) dut (
        .clock (clock),
        .reset (reset),
        .J     (J),
        .K     (K),
        .load  (load),
        .din   (din),
        .Q     (Q),
        .borrow(borrow),
        .zero  (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of the DUT against the model, away from the active edge
    always @(negedge clock) begin
        if (model_valid) begin
            check("cyc_Q", int'(Q), m_q);
            check("cyc_borrow", int'(borrow), m_b);
            check("cyc_zero", int'(zero), (m_q == 0) ? 1 : 0);
        end
    end

    // Apply one edge of stimulus and advance the model by the arithmetic rules
    task automatic step(input bit r, input bit j, input bit k, input bit l, input int d);
        int nq;
        int nb;
        reset = r; J = j; K = k; load = l; din = WIDTH'(d);
        nq = m_q;
        nb = 0;
        if (r) begin
            nq = 0;
        end else if (l) begin
            nq = (SAT != 0 && d >= MOD) ? MOD - 1 : d;
        end else if (!j && k) begin
            nq = 0;
        end else if (j && !k) begin
            nq = TOP;
        end else if (j && k) begin
            if (SAT != 0 && m_q >= MOD) begin
                nq = TOP;
            end else if (m_q == 0) begin
                nq = TOP;
                nb = 1;
            end else begin
                nq = m_q - 1;
            end
        end
        @(posedge clock);
        #1;
        m_q = nq;
        m_b = nb;
        if (r) model_valid = 1'b1;
    endtask

    task automatic expect_out(input string name, input int eq, input int eb);
        check({name, "_Q"}, int'(Q), eq);
        check({name, "_borrow"}, int'(borrow), eb);
    endtask

    int exp2_q [5];
    int exp2_b [5] = '{0, 0, 0, 1, 0};

    initial begin
        reset = 1'b0; J = 1'b0; K = 1'b0; load = 1'b0; din = '0;
        if (SAT != 0) exp2_q = '{2, 1, 0, 9, 8};
        else          exp2_q = '{2, 1, 0, 15, 14};

        // 1. reset held for two edges while counting is requested
        step(1, 1, 1, 0, 0);
        step(1, 1, 1, 0, 0);
        expect_out("reset", 0, 0);
        check("reset_zero", int'(zero), 1);

        // 2. load 3 then count five edges
        step(0, 0, 0, 1, 3);
        expect_out("load3", 3, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 0, 0);
            expect_out("cnt_from3", exp2_q[i], exp2_b[i]);
        end

        // 3. wrap from 0, then TOP-1, then consecutive wrap after TOP more edges
        step(0, 0, 1, 0, 0);
        expect_out("clear", 0, 0);
        step(0, 1, 1, 0, 0);
        expect_out("wrap1", TOP, 1);
        step(0, 1, 1, 0, 0);
        expect_out("after_wrap", TOP - 1, 0);
        for (int i = 0; i < TOP; i++) step(0, 1, 1, 0, 0);
        expect_out("wrap2", TOP, 1);

        // 4. hold, clear, set
        step(0, 0, 0, 1, 6);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            expect_out("hold", 6, 0);
        end
        step(0, 0, 1, 0, 0);
        expect_out("clear6", 0, 0);
        check("clear_zero", int'(zero), 1);
        step(0, 1, 0, 0, 0);
        expect_out("set", (SAT != 0) ? 9 : 15, 0);

        // 5. out-of-range load and all-ones load
        step(0, 0, 0, 1, 12);
        expect_out("load12", (SAT != 0) ? 9 : 12, 0);
        step(0, 0, 0, 1, 15);
        expect_out("load15", (SAT != 0) ? 9 : 15, 0);
        step(0, 1, 1, 0, 0);
        expect_out("cnt_from15", (SAT != 0) ? 8 : 14, 0);

        // 6. load beats a due wrap; reset mid-count; reset beats a due wrap
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 1, 4);
        expect_out("load_vs_wrap", 4, 0);
        step(0, 0, 0, 1, 6);
        step(0, 1, 1, 0, 0);
        expect_out("cnt_to5", 5, 0);
        step(1, 1, 1, 0, 0);
        expect_out("reset_mid", 0, 0);
        step(1, 1, 1, 0, 0);
        expect_out("reset_vs_wrap", 0, 0);
        step(0, 1, 1, 0, 0);
        expect_out("wrap_after_reset", TOP, 1);
        step(0, 0, 0, 0, 0);
        expect_out("hold_after_wrap", TOP, 0);

        @(negedge clock);
        model_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
